user_module_phase_seq: RTL and testbench

USER_MODULE_PHASE_SEQ -- requirements
Module: user_module_phase_seq

---
 rtl/user_module_phase_seq_pkg.sv | 30 +++
 rtl/user_module_phase_seq_if.sv | 10 +
 rtl/user_module_phase_seq_sync2.sv | 29 ++
 rtl/user_module_phase_seq.sv | 122 ++++++++++++
 tb/tb_user_module_phase_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/user_module_phase_seq_pkg.sv
// Shared types and widths for the four-phase sequencer.
package user_module_phase_seq_pkg;

  localparam int unsigned IO_W    = 8;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_e;

  // io_in bit map, MSB first
  typedef struct packed {
    logic [CNT_W-1:0] dwell;
    logic             step;
    logic             run;
    logic             rst_n;
    logic             clk;
  } pins_t;

  // io_out bit map, MSB first
  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic [CNT_W-1:0]   count;
    logic               wrap;
    logic               adv;
  } status_t;

endpackage

// File: rtl/user_module_phase_seq_if.sv
// Pin bundle carrying the sequencer's packed io_in / io_out buses.
interface user_module_phase_seq_if;
  import user_module_phase_seq_pkg::*;

  logic [IO_W-1:0] io_in;
  logic [IO_W-1:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/user_module_phase_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module user_module_phase_seq_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/user_module_phase_seq.sv
// Four-phase sequencer: free-running with programmable dwell, or manual stepping.
module user_module_phase_seq
  import user_module_phase_seq_pkg::*;
(
  user_module_phase_seq_if.slave bus
);

  pins_t   pins;
  status_t status;
  logic    clk;
  logic    rst_n;

  assign pins  = pins_t'(bus.io_in);
  assign clk   = pins.clk;
  assign rst_n = pins.rst_n;

  logic run_s;
  logic step_s;
  logic step_rise;

  user_module_phase_seq_sync2 u_sync2_run (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pins.run),
    .q     (run_s)
  );

  user_module_phase_seq_sync2 u_sync2_step (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pins.step),
    .q     (step_s)
  );

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 adv_q, adv_d;
  logic                 wrap_q, wrap_d;
  logic                 step_dly_q, step_dly_d;
  logic                 advance;

  assign step_rise = step_s & ~step_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = STOP;
    if (run_s) begin
      state_d = RUN;
    end
  end

  // Entering RUN only loads the count; a step edge on that same cycle is dropped.
  always_comb begin
    phase_d    = phase_q;
    count_d    = count_q;
    adv_d      = 1'b0;
    wrap_d     = 1'b0;
    step_dly_d = step_s;
    advance    = 1'b0;
    case (state_q)
      STOP: begin
        if (run_s) begin
          count_d = pins.dwell;
        end else if (step_rise) begin
          advance = 1'b1;
        end
      end
      RUN: begin
        if (run_s) begin
          if (count_q == '0) begin
            advance = 1'b1;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      default: begin
        advance = 1'b0;
      end
    endcase
    if (advance) begin
      phase_d = phase_q + PHASE_W'(1);
      count_d = pins.dwell;
      adv_d   = 1'b1;
      wrap_d  = (phase_q == PHASE_W'(3));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= '0;
      count_q    <= '0;
      adv_q      <= 1'b0;
      wrap_q     <= 1'b0;
      step_dly_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      count_q    <= count_d;
      adv_q      <= adv_d;
      wrap_q     <= wrap_d;
      step_dly_q <= step_dly_d;
    end
  end

  always_comb begin
    status.phase = phase_q;
    status.count = count_q;
    status.wrap  = wrap_q;
    status.adv   = adv_q;
  end

  assign bus.io_out = IO_W'(status);

endmodule

// File: tb/tb_user_module_phase_seq.sv
// Directed and randomized checks of the phase sequencer against a pin-level model.
module tb_user_module_phase_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       run   = 1'b0;
  logic       step  = 1'b0;
  logic [3:0] dwell = 4'd0;

  int checks    = 0;
  int errors    = 0;
  int adv_seen  = 0;
  int wrap_seen = 0;

  user_module_phase_seq_if bus ();

  assign bus.io_in = {dwell, step, run, rst_n, clk};

  user_module_phase_seq dut (
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: phase/count as plain integers, pins delayed by whole edges.
  int m_phase, m_cnt;
  bit m_adv, m_wrap, m_running;
  bit r1, r2, s1, s2, s3;

  function automatic void m_clear();
    m_phase = 0; m_cnt = 0; m_adv = 0; m_wrap = 0; m_running = 0;
    r1 = 0; r2 = 0; s1 = 0; s2 = 0; s3 = 0;
  endfunction

  function automatic void m_advance();
    m_wrap  = (m_phase == 3);
    m_phase = (m_phase + 1) % 4;
    m_cnt   = int'(dwell);
    m_adv   = 1;
  endfunction

  function automatic logic [7:0] model_out();
    return {2'(m_phase), 4'(m_cnt), m_wrap, m_adv};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One clock edge: advance the model, then compare the DUT shortly after the edge.
  task automatic tick(input string tag);
    bit run_eff, rise;
    @(posedge clk);
    if (!rst_n) begin
      m_clear();
    end else begin
      run_eff = r2;
      rise    = s2 && !s3;
      m_adv   = 0;
      m_wrap  = 0;
      if (m_running) begin
        if (run_eff) begin
          if (m_cnt == 0) m_advance();
          else m_cnt = m_cnt - 1;
        end
      end else if (run_eff) begin
        m_cnt = int'(dwell);
      end else if (rise) begin
        m_advance();
      end
      m_running = run_eff;
      s3 = s2; s2 = s1; s1 = step;
      r2 = r1; r1 = run;
    end
    #1;
    check_eq(tag, bus.io_out, model_out());
    if (bus.io_out[0]) adv_seen++;
    if (bus.io_out[1]) wrap_seen++;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    m_clear();
    #1;
    check_eq("reset_async", bus.io_out, 8'h00);
    repeat (cycles) tick("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    #2;

    // Reset with run high and dwell 9: outputs 0, STOP until run sync completes.
    run = 1'b1; dwell = 4'd9;
    do_reset(3);
    tick("rst_sync1");
    tick("rst_sync2");
    check_eq("rst_still_stop", bus.io_out, 8'h00);
    tick("rst_load");
    check_eq("rst_first_load", bus.io_out, 8'h24);

    // Free run with dwell 2: advance every 3rd cycle, wrap once per 12.
    run = 1'b0;
    do_reset(2);
    dwell = 4'd2; run = 1'b1;
    repeat (3) tick("free_start");
    adv_seen = 0; wrap_seen = 0;
    repeat (24) tick("free_run");
    check_eq("free_adv_count", 8'(adv_seen), 8'd8);
    check_eq("free_wrap_count", 8'(wrap_seen), 8'd2);

    // Dwell 5 -> 1 at count 3: phase 0 finishes, phase 1 lasts 2 cycles.
    run = 1'b0;
    do_reset(2);
    dwell = 4'd5; run = 1'b1;
    repeat (3) tick("dw_start");
    repeat (2) tick("dw_dec");
    check_eq("dw_at3", bus.io_out, 8'h0C);
    dwell = 4'd1;
    repeat (3) tick("dw_finish");
    check_eq("dw_count0", bus.io_out, 8'h00);
    tick("dw_adv1");
    check_eq("dw_phase1", bus.io_out, 8'h45);
    tick("dw_p1_c0");
    check_eq("dw_phase1_end", bus.io_out, 8'h40);
    tick("dw_adv2");
    check_eq("dw_phase2", bus.io_out, 8'h85);

    // Manual stepping: three wide pulses, three advances.
    run = 1'b0;
    do_reset(2);
    dwell = 4'd7;
    adv_seen = 0;
    repeat (3) begin
      step = 1'b1; repeat (4) tick("step_hi");
      step = 1'b0; repeat (4) tick("step_lo");
    end
    check_eq("step_adv_count", 8'(adv_seen), 8'd3);
    check_eq("step_final", bus.io_out, 8'hDC);

    // Stop at phase 2 count 4, freeze, then resume with reload.
    do_reset(2);
    dwell = 4'd6; run = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick("ss_seek");
      if (bus.io_out[7:2] == 6'b10_0100) found = 1;
    end
    check_eq("ss_reached", 8'(found), 8'd1);
    run = 1'b0;
    repeat (3) tick("ss_drain");
    check_eq("ss_frozen", bus.io_out, 8'h88);
    repeat (5) tick("ss_hold");
    check_eq("ss_still_frozen", bus.io_out, 8'h88);
    dwell = 4'd3; run = 1'b1;
    repeat (2) tick("ss_resync");
    check_eq("ss_not_yet", bus.io_out, 8'h88);
    tick("ss_reload");
    check_eq("ss_resumed", bus.io_out, 8'h8C);

    // Dwell 0: advance every cycle, then async reset mid-phase.
    run = 1'b0;
    do_reset(2);
    dwell = 4'd0; run = 1'b1;
    repeat (3) tick("d0_start");
    check_eq("d0_loaded", bus.io_out, 8'h00);
    repeat (8) begin
      tick("d0_run");
      check_eq("d0_adv_high", {7'd0, bus.io_out[0]}, 8'd1);
    end
    #2;
    do_reset(2);

    // Step held high through reset release: exactly one advance.
    run = 1'b0; step = 1'b1; dwell = 4'd5;
    do_reset(2);
    adv_seen = 0;
    repeat (10) tick("held_step");
    check_eq("held_step_advs", 8'(adv_seen), 8'd1);
    check_eq("held_step_out", bus.io_out, 8'h54);
    step = 1'b0;

    // Randomized pins against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 3) == 0) step = ~step;
      if ($urandom_range(0, 7) == 0) dwell = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 249) == 0) do_reset(2);
      else tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
